// File: rtl/sprite_pkg.sv
// Sprite attribute word layout, size-code decode and fetch FSM encoding.
package sprite_pkg;

  localparam int SPRITE_COUNT = 128;
  localparam logic [6:0] LAST_IDX = 7'(SPRITE_COUNT - 1);

  localparam int W0_ADDR_LSB  = 0;
  localparam int W0_ADDR_MSB  = 11;
  localparam int W0_MODE      = 15;
  localparam int W0_X_LSB     = 16;
  localparam int W0_X_MSB     = 25;

  localparam int W1_Y_LSB     = 0;
  localparam int W1_Y_MSB     = 9;
  localparam int W1_HFLIP     = 16;
  localparam int W1_VFLIP     = 17;
  localparam int W1_Z_LSB     = 18;
  localparam int W1_Z_MSB     = 19;
  localparam int W1_CMASK_LSB = 20;
  localparam int W1_CMASK_MSB = 23;
  localparam int W1_PAL_LSB   = 24;
  localparam int W1_PAL_MSB   = 27;
  localparam int W1_WIDTH_LSB = 28;
  localparam int W1_WIDTH_MSB = 29;
  localparam int W1_HGT_LSB   = 30;
  localparam int W1_HGT_MSB   = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_EVAL,
    ST_OUT,
    ST_DONE
  } fetch_state_t;

  // Size codes 0..3 select 8/16/32/64 pixels.
  function automatic logic [6:0] size_px(input logic [1:0] code);
    return 7'd8 << code;
  endfunction

endpackage

// File: rtl/sprite_attr_decode.sv
// Combinational unpack of one sprite's W0/W1 words plus the per-line visibility test.
module sprite_attr_decode
  import sprite_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [9:0]  line,
  output logic [11:0] addr,
  output logic        mode,
  output logic [9:0]  x,
  output logic        hflip,
  output logic [1:0]  z,
  output logic [3:0]  cmask,
  output logic [3:0]  pal,
  output logic [1:0]  width,
  output logic [1:0]  height,
  output logic        visible,
  output logic [5:0]  row
);

  logic [9:0] y;
  logic       vflip;
  logic [6:0] height_px;
  logic [5:0] height_m1;
  logic [9:0] d;
  logic       unused_bits;

  assign addr   = w0[W0_ADDR_MSB:W0_ADDR_LSB];
  assign mode   = w0[W0_MODE];
  assign x      = w0[W0_X_MSB:W0_X_LSB];
  assign y      = w1[W1_Y_MSB:W1_Y_LSB];
  assign hflip  = w1[W1_HFLIP];
  assign vflip  = w1[W1_VFLIP];
  assign z      = w1[W1_Z_MSB:W1_Z_LSB];
  assign cmask  = w1[W1_CMASK_MSB:W1_CMASK_LSB];
  assign pal    = w1[W1_PAL_MSB:W1_PAL_LSB];
  assign width  = w1[W1_WIDTH_MSB:W1_WIDTH_LSB];
  assign height = w1[W1_HGT_MSB:W1_HGT_LSB];

  assign unused_bits = ^{w0[14:12], w0[31:26], w1[15:10]};

  // 10-bit subtraction wraps, so sprites straddling line 1023/0 stay visible.
  assign height_px = size_px(height);
  assign height_m1 = 6'(height_px - 7'd1);
  assign d         = line - y;
  assign visible   = (z != 2'd0) && (d < {3'b000, height_px});
  assign row       = vflip ? (height_m1 - d[5:0]) : d[5:0];

endmodule

// File: rtl/sprite_attr_fetch.sv
// Scans all sprite attribute entries for one display line and streams visible descriptors.
module sprite_attr_fetch
  import sprite_pkg::*;
#(
  parameter int MAX_PER_LINE = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [9:0]  line_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic        rd_en_o,
  output logic [7:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        spr_valid_o,
  input  logic        spr_ready_i,
  output logic [6:0]  spr_idx_o,
  output logic [11:0] spr_addr_o,
  output logic        spr_mode_o,
  output logic [9:0]  spr_x_o,
  output logic [5:0]  spr_row_o,
  output logic        spr_hflip_o,
  output logic [1:0]  spr_z_o,
  output logic [3:0]  spr_cmask_o,
  output logic [3:0]  spr_pal_o,
  output logic [1:0]  spr_width_o,
  output logic [1:0]  spr_height_o
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_PER_LINE);

  fetch_state_t state;
  logic [6:0]   n;
  logic [7:0]   vis_cnt;
  logic [9:0]   line_q;
  logic [31:0]  w0_q;

  logic [11:0] d_addr;
  logic        d_mode;
  logic [9:0]  d_x;
  logic        d_hflip;
  logic [1:0]  d_z;
  logic [3:0]  d_cmask;
  logic [3:0]  d_pal;
  logic [1:0]  d_width;
  logic [1:0]  d_height;
  logic        d_visible;
  logic [5:0]  d_row;

  // In EVAL the read port is presenting W1 directly.
  sprite_attr_decode u_decode (
    .w0      (w0_q),
    .w1      (rd_data_i),
    .line    (line_q),
    .addr    (d_addr),
    .mode    (d_mode),
    .x       (d_x),
    .hflip   (d_hflip),
    .z       (d_z),
    .cmask   (d_cmask),
    .pal     (d_pal),
    .width   (d_width),
    .height  (d_height),
    .visible (d_visible),
    .row     (d_row)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      n            <= '0;
      vis_cnt      <= '0;
      line_q       <= '0;
      w0_q         <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      overflow_o   <= 1'b0;
      rd_en_o      <= 1'b0;
      rd_addr_o    <= '0;
      spr_valid_o  <= 1'b0;
      spr_idx_o    <= '0;
      spr_addr_o   <= '0;
      spr_mode_o   <= 1'b0;
      spr_x_o      <= '0;
      spr_row_o    <= '0;
      spr_hflip_o  <= 1'b0;
      spr_z_o      <= '0;
      spr_cmask_o  <= '0;
      spr_pal_o    <= '0;
      spr_width_o  <= '0;
      spr_height_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            line_q     <= line_i;
            n          <= '0;
            vis_cnt    <= '0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b1;
            rd_en_o    <= 1'b1;
            rd_addr_o  <= 8'd0;
            state      <= ST_RD0;
          end
        end
        ST_RD0: begin
          rd_addr_o <= {n, 1'b1};
          state     <= ST_RD1;
        end
        ST_RD1: begin
          w0_q    <= rd_data_i;
          rd_en_o <= 1'b0;
          state   <= ST_EVAL;
        end
        ST_EVAL: begin
          if (!d_visible) begin
            if (n == LAST_IDX) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              n         <= n + 7'd1;
              rd_en_o   <= 1'b1;
              rd_addr_o <= {n + 7'd1, 1'b0};
              state     <= ST_RD0;
            end
          end else if (vis_cnt < MAX_CNT) begin
            spr_valid_o  <= 1'b1;
            spr_idx_o    <= n;
            spr_addr_o   <= d_addr;
            spr_mode_o   <= d_mode;
            spr_x_o      <= d_x;
            spr_row_o    <= d_row;
            spr_hflip_o  <= d_hflip;
            spr_z_o      <= d_z;
            spr_cmask_o  <= d_cmask;
            spr_pal_o    <= d_pal;
            spr_width_o  <= d_width;
            spr_height_o <= d_height;
            state        <= ST_OUT;
          end else begin
            overflow_o <= 1'b1;
            done_o     <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_OUT: begin
          if (spr_ready_i) begin
            spr_valid_o <= 1'b0;
            vis_cnt     <= vis_cnt + 8'd1;
            if (n == LAST_IDX) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              n         <= n + 7'd1;
              rd_en_o   <= 1'b1;
              rd_addr_o <= {n + 7'd1, 1'b0};
              state     <= ST_RD0;
            end
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_attr_fetch.sv
// Directed bench for sprite_attr_fetch with a one-cycle-latency attribute RAM model.
module tb_sprite_attr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  line_i = '0;
  logic        busy_o, done_o, overflow_o, rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [31:0] rd_data_i = '0;
  logic        spr_valid_o;
  logic        spr_ready_i = 1'b1;
  logic [6:0]  spr_idx_o;
  logic [11:0] spr_addr_o;
  logic        spr_mode_o;
  logic [9:0]  spr_x_o;
  logic [5:0]  spr_row_o;
  logic        spr_hflip_o;
  logic [1:0]  spr_z_o;
  logic [3:0]  spr_cmask_o;
  logic [3:0]  spr_pal_o;
  logic [1:0]  spr_width_o;
  logic [1:0]  spr_height_o;

  typedef struct {
    int idx, addr, mode, x, row, hflip, z, cmask, pal, width, height;
  } desc_t;

  logic [31:0] mem [256];
  desc_t       got [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  sprite_attr_fetch #(.MAX_PER_LINE(16)) dut (
    .clk_i, .rst_n_i, .start_i, .line_i, .busy_o, .done_o, .overflow_o,
    .rd_en_o, .rd_addr_o, .rd_data_i, .spr_valid_o, .spr_ready_i,
    .spr_idx_o, .spr_addr_o, .spr_mode_o, .spr_x_o, .spr_row_o,
    .spr_hflip_o, .spr_z_o, .spr_cmask_o, .spr_pal_o, .spr_width_o,
    .spr_height_o
  );

  task automatic check(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  function automatic logic [31:0] mk_w0(int addr, int mode, int x);
    return 32'(addr | (mode << 15) | (x << 16));
  endfunction

  function automatic logic [31:0] mk_w1(int y, int hf, int vf, int z, int cm, int pal, int w, int h);
    return 32'(y | (hf << 16) | (vf << 17) | (z << 18) | (cm << 20) | (pal << 24) | (w << 28) | (h << 30));
  endfunction

  // Starts a scan, logs every transfer, returns cycles with the start cycle counted as 1.
  task automatic run_scan(input logic [9:0] line, input int restart_at, output int cycles);
    desc_t d;
    bit    seen;
    got.delete();
    seen = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    line_i  = line;
    cycles  = 1;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(posedge clk_i); #1;
      start_i = (cycles + 1 == restart_at);
      line_i  = start_i ? 10'd500 : line;
      cycles++;
      if (spr_valid_o && spr_ready_i) begin
        d.idx = spr_idx_o;  d.addr = spr_addr_o;   d.mode = spr_mode_o;
        d.x = spr_x_o;      d.row = spr_row_o;     d.hflip = spr_hflip_o;
        d.z = spr_z_o;      d.cmask = spr_cmask_o; d.pal = spr_pal_o;
        d.width = spr_width_o; d.height = spr_height_o;
        got.push_back(d);
      end
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    check("done_seen", int'(seen), 1);
    @(posedge clk_i); #1;
    check("done_one_cycle", int'(done_o), 0);
    check("busy_after_done", int'(busy_o), 0);
  endtask

  initial begin
    int  lat;
    bit  ok;
    clear_mem();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_ovf", int'(overflow_o), 0);
    check("rst_rd_en", int'(rd_en_o), 0);
    check("rst_rd_addr", int'(rd_addr_o), 0);
    check("rst_valid", int'(spr_valid_o), 0);
    check("rst_idx", int'(spr_idx_o), 0);
    rst_n_i = 1'b1;

    // Single visible sprite at index 1.
    mem[2] = mk_w0(12'h100, 1, 60);
    mem[3] = mk_w1(3, 0, 0, 1, 0, 0, 2, 1);
    spr_ready_i = 1'b1;
    run_scan(10'd10, 0, lat);
    check("a_count", got.size(), 1);
    if (got.size() >= 1) begin
      check("a_idx", got[0].idx, 1);
      check("a_addr", got[0].addr, 'h100);
      check("a_mode", got[0].mode, 1);
      check("a_x", got[0].x, 60);
      check("a_row", got[0].row, 7);
      check("a_width", got[0].width, 2);
      check("a_height", got[0].height, 1);
      check("a_z", got[0].z, 1);
    end
    check("a_ovf", int'(overflow_o), 0);

    // d = 16 is just outside a 16-pixel sprite; a mid-scan start must be ignored.
    run_scan(10'd19, 50, lat);
    check("b_count", got.size(), 0);
    check("b_latency", lat, 386);

    mem[3] = mk_w1(3, 0, 1, 1, 0, 0, 2, 1);
    run_scan(10'd10, 0, lat);
    check("c_count", got.size(), 1);
    if (got.size() >= 1) check("c_vflip_row", got[0].row, 8);

    // Wrap-around: y=1020, 8 rows, line 2 gives d=6.
    clear_mem();
    mem[10] = mk_w0(12'hABC, 0, 1000);
    mem[11] = mk_w1(1020, 1, 0, 2, 4'hA, 4'h5, 0, 0);
    run_scan(10'd2, 0, lat);
    check("d_count", got.size(), 1);
    if (got.size() >= 1) begin
      check("d_idx", got[0].idx, 5);
      check("d_row", got[0].row, 6);
      check("d_addr", got[0].addr, 'hABC);
      check("d_x", got[0].x, 1000);
      check("d_hflip", got[0].hflip, 1);
      check("d_z", got[0].z, 2);
      check("d_cmask", got[0].cmask, 10);
      check("d_pal", got[0].pal, 5);
    end

    // 17 visible sprites against a limit of 16.
    clear_mem();
    for (int i = 0; i < 17; i++) begin
      mem[2*i]   = mk_w0(i, 0, i);
      mem[2*i+1] = mk_w1(0, 0, 0, 1, 0, 0, 0, 0);
    end
    run_scan(10'd0, 0, lat);
    check("e_count", got.size(), 16);
    ok = 1'b1;
    foreach (got[i]) if (got[i].idx != i) ok = 1'b0;
    check("e_order", int'(ok), 1);
    check("e_ovf", int'(overflow_o), 1);

    // Back-pressure: five stalled cycles, transfer on the sixth.
    clear_mem();
    mem[2] = mk_w0(12'h100, 1, 60);
    mem[3] = mk_w1(3, 0, 0, 1, 0, 0, 2, 1);
    spr_ready_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1; line_i = 10'd10;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("f_ovf_cleared", int'(overflow_o), 0);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (spr_valid_o) ok = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    check("f_valid_seen", int'(ok), 1);
    for (int i = 0; i < 5; i++) begin
      check("f_hold_valid", int'(spr_valid_o), 1);
      check("f_hold_rd_en", int'(rd_en_o), 0);
      check("f_hold_idx", int'(spr_idx_o), 1);
      check("f_hold_addr", int'(spr_addr_o), 'h100);
      check("f_hold_x", int'(spr_x_o), 60);
      check("f_hold_row", int'(spr_row_o), 7);
      check("f_hold_width", int'(spr_width_o), 2);
      @(posedge clk_i); #1;
    end
    check("f_valid_6th", int'(spr_valid_o), 1);
    spr_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("f_valid_after_xfer", int'(spr_valid_o), 0);
    ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(posedge clk_i); #1;
      if (done_o) ok = 1'b1;
    end
    check("f_done", int'(ok), 1);

    // Reset while a descriptor is pending, then rescan.
    mem[0] = mk_w0(12'h010, 0, 5);
    mem[1] = mk_w1(3, 0, 0, 1, 0, 0, 0, 1);
    spr_ready_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1; line_i = 10'd10;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (spr_valid_o) ok = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    check("g_valid_seen", int'(ok), 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("g_rst_valid", int'(spr_valid_o), 0);
    check("g_rst_busy", int'(busy_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    spr_ready_i = 1'b1;
    run_scan(10'd10, 0, lat);
    check("g_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("g_first_idx", got[0].idx, 0);
      check("g_second_idx", got[1].idx, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_attr_fetch.md
SPRITE_ATTR_FETCH -- requirements
Module: sprite_attr_fetch

Interface
REQ-001 SHALL have parameter MAX_PER_LINE, default 16, meaning the maximum number of visible sprites emitted per line (1..128).
REQ-002 SHALL have one clock; reset is asynchronous and active-low: clk_i input 1 (sole clock), rst_n_i input 1 (async active-low reset).
REQ-003 start_i input 1: pulse that begins a scan for line_i.
REQ-004 line_i input 10: display line number, sampled on start_i.
REQ-005 busy_o output 1: scan in progress.
REQ-006 done_o output 1: one-cycle pulse at scan end.
REQ-007 overflow_o output 1: more than MAX_PER_LINE sprites are visible on the last scanned line.
REQ-008 rd_en_o output 1; rd_addr_o output 8; rd_data_i input 32: sprite attribute RAM read port, data valid one cycle after the address.
REQ-009 spr_valid_o output 1; spr_ready_i input 1: descriptor handshake.
REQ-010 Descriptor outputs: spr_idx_o 7, spr_addr_o 12, spr_mode_o 1, spr_x_o 10, spr_row_o 6, spr_hflip_o 1, spr_z_o 2, spr_cmask_o 4, spr_pal_o 4, spr_width_o 2, spr_height_o 2.

Function
REQ-011 Sprite n SHALL occupy word 2n (W0) and word 2n+1 (W1); W0: [11:0] addr, [15] mode, [25:16] x; W1: [9:0] y, [16] hflip, [17] vflip, [19:18] z, [23:20] cmask, [27:24] palette, [29:28] width, [31:30] height.
REQ-012 FSM states SHALL be IDLE, RD0, RD1, EVAL, OUT, DONE.
REQ-013 IDLE->RD0 on start_i: latch line_i, set n=0, clear the visible count and overflow_o.
REQ-014 RD0 SHALL drive rd_addr_o=2n with rd_en_o=1; RD1 SHALL drive 2n+1 with rd_en_o=1 and capture W0; EVAL SHALL capture W1.
REQ-015 rd_en_o SHALL be 0 outside RD0 and RD1.
REQ-016 Height and width codes 0/1/2/3 SHALL mean 8/16/32/64 pixels.
REQ-017 In EVAL, a sprite SHALL be visible iff z!=0 and d=(line-y) mod 1024 < height_px, computed in 10-bit wrap-around arithmetic.
REQ-018 spr_row_o SHALL be d when vflip=0, and height_px-1-d when vflip=1.
REQ-019 EVAL, sprite not visible: go to RD0 with n+1, or to DONE if n=127; an invisible sprite costs 3 cycles.
REQ-020 EVAL, sprite visible and count<MAX_PER_LINE: go to OUT, with spr_valid_o=1 on the following cycle and all descriptor fields registered.
REQ-021 In OUT, spr_valid_o and every descriptor field SHALL stay stable until spr_ready_i=1; on the transfer cycle, increment the count and advance as in REQ-019.
REQ-022 EVAL, sprite visible and count==MAX_PER_LINE: set overflow_o=1 and go to DONE without emitting that sprite.
REQ-023 DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-024 overflow_o SHALL hold until the next start_i.
REQ-025 busy_o SHALL be 1 in every state except IDLE.
REQ-026 start_i while busy_o=1 SHALL be ignored.
REQ-027 A start_i in the same cycle as the DONE state SHALL be ignored.

Reset
REQ-028 rst_n_i low SHALL force IDLE asynchronously, mid-scan included, with no descriptor emitted.
REQ-029 Reset values: every output 0, n=0, visible count=0, latched line=0.
REQ-030 Reset SHALL be released synchronously to clk_i by the system; the block needs no internal synchronizer.

Structure
REQ-031 Package sprite_pkg SHALL hold the W0/W1 field bit positions, the size-code-to-pixel decode, the FSM state encoding and SPRITE_COUNT=128.
REQ-032 Sub-module sprite_attr_decode (combinational) SHALL take W0, W1 and line and produce the decoded fields, visible and row; sprite_attr_fetch SHALL hold the FSM, counters and output registers.
REQ-033 No memory SHALL be inferred in this block.

Verification
REQ-034 Sprite 1: W0 addr=0x100, mode=1, x=60; W1 y=3, z=1, width=2, height=1; others z=0; line 10 -> one descriptor, idx=1, addr=0x100, x=60, row=7, width=2; done_o after the 128th sprite; overflow_o=0.
REQ-035 Same RAM, line 19 -> no descriptor (d=16 not <16); done_o after exactly 384+2 cycles from start_i.
REQ-036 Sprite 1 with vflip=1, line 10 -> row=8; y=1020, height=0, line 2 -> visible, row=6 (wrap-around).
REQ-037 17 sprites visible on line 0, MAX_PER_LINE=16 -> idx 0..15 emitted in order, overflow_o=1, done_o, the 17th never emitted.
REQ-038 spr_ready_i held low for 5 cycles with spr_valid_o=1 -> all fields unchanged and rd_en_o=0 throughout; transfer on the 6th cycle.
REQ-039 rst_n_i low during OUT -> spr_valid_o=0 and busy_o=0 immediately; a later start_i rescans from sprite 0.
